// File: rtl/nanorv32_irq_ctrl_pkg.sv
// Shared definitions for the nanorv32 interrupt controller: FSM states,
// register indices and source-count limits.
package nanorv32_irq_ctrl_pkg;

    localparam int unsigned IRQ_NB_MAX = 32;
    localparam int unsigned IRQ_ID_W   = 5;

    localparam logic [1:0] REG_ENABLE  = 2'd0;
    localparam logic [1:0] REG_PENDING = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/nanorv32_irq_ctrl_prio.sv
// Combinational fixed-priority encoder: lowest set request index wins.
module nanorv32_irq_prio
    import nanorv32_irq_ctrl_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]          req_i,
    output logic                  valid_o,
    output logic [IRQ_ID_W-1:0]   idx_o
);

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req_i[i] && !valid_o) begin
                valid_o = 1'b1;
                idx_o   = IRQ_ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/nanorv32_irq_ctrl.sv
// nanorv32 interrupt controller: level/edge pending, enable mask, fixed priority,
// IDLE/REQ/SERVICE handshake. Optional input synchronizer: NANORV32_IRQ_SYNC_EN.
module nanorv32_irq_ctrl
    import nanorv32_irq_ctrl_pkg::*;
#(
    parameter int unsigned         IRQ_NB   = 8,
    parameter logic [IRQ_NB-1:0]   IRQ_EDGE = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IRQ_NB-1:0]    irq_src,
    input  logic                 cfg_sel,
    input  logic                 cfg_we,
    input  logic [1:0]           cfg_addr,
    input  logic [31:0]          cfg_wdata,
    output logic [31:0]          cfg_rdata,
    input  logic                 interrupt_state,
    output logic                 irq,
    output logic [4:0]           irq_id
);

    logic [IRQ_NB-1:0]   src_s;
    logic [IRQ_NB-1:0]   hist_q;
    logic [IRQ_NB-1:0]   en_q, en_d;
    logic [IRQ_NB-1:0]   pend_q, pend_d;
    logic [IRQ_NB-1:0]   cand, w1c, ack_clr;
    irq_state_e          state_q, state_d;
    logic [4:0]          id_q, id_d;
    logic                irq_q;
    logic                ist_q;
    logic                ack, fall, cfg_wr, still_cand;
    logic                win_valid;
    logic [4:0]          win_idx;
    logic                unused_wdata;

    assign unused_wdata = ^cfg_wdata;

`ifdef NANORV32_IRQ_SYNC_EN
    logic [IRQ_NB-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_src;
            sync2_q <= sync1_q;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = irq_src;
`endif

    nanorv32_irq_prio #(.N(IRQ_NB)) u_prio (
        .req_i   (cand),
        .valid_o (win_valid),
        .idx_o   (win_idx)
    );

    always_comb begin
        cand   = pend_q & en_q;
        ack    = interrupt_state & ~ist_q;
        fall   = ~interrupt_state & ist_q;
        cfg_wr = cfg_sel & cfg_we;

        en_d = en_q;
        if (cfg_wr && cfg_addr == REG_ENABLE) en_d = cfg_wdata[IRQ_NB-1:0];
        w1c = '0;
        if (cfg_wr && cfg_addr == REG_PENDING) w1c = cfg_wdata[IRQ_NB-1:0] & IRQ_EDGE;

        still_cand = 1'b0;
        for (int unsigned i = 0; i < IRQ_NB; i++) begin
            if (id_q == 5'(i) && cand[i]) still_cand = 1'b1;
        end

        state_d = state_q;
        id_d    = id_q;
        ack_clr = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (win_valid && !interrupt_state) begin
                    id_d    = win_idx;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // acknowledge takes precedence over withdrawal
                if (ack) begin
                    state_d = ST_SERVICE;
                    for (int unsigned i = 0; i < IRQ_NB; i++) begin
                        ack_clr[i] = (id_q == 5'(i));
                    end
                end else if (!still_cand) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (fall) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // edge bits: new rise wins over any clear in the same cycle
        pend_d = (IRQ_EDGE & ((pend_q & ~(w1c | (ack_clr & IRQ_EDGE))) | (src_s & ~hist_q)))
               | (~IRQ_EDGE & src_s);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            irq_q   <= 1'b0;
            ist_q   <= 1'b0;
            en_q    <= '0;
            pend_q  <= '0;
            hist_q  <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            irq_q   <= (state_d == ST_REQ);
            ist_q   <= interrupt_state;
            en_q    <= en_d;
            pend_q  <= pend_d;
            hist_q  <= src_s;
        end
    end

    always_comb begin
        cfg_rdata = '0;
        unique case (cfg_addr)
            REG_ENABLE:  cfg_rdata = 32'(en_q);
            REG_PENDING: cfg_rdata = 32'(pend_q);
            REG_STATUS: begin
                cfg_rdata[0]    = irq_q;
                cfg_rdata[1]    = (state_q == ST_SERVICE);
                cfg_rdata[12:8] = id_q;
            end
            default: cfg_rdata = '0;
        endcase
    end

    assign irq    = irq_q;
    assign irq_id = id_q;

endmodule

// File: tb/tb_nanorv32_irq_ctrl.sv
// Scoreboard bench for nanorv32_irq_ctrl: driver pushes model expectations,
// negedge monitor pops and compares irq, irq_id and register reads.
module tb_nanorv32_irq_ctrl;

    localparam logic [7:0] EDGE = 8'hF5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  irq_src = '0;
    logic        cfg_sel = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic [31:0] cfg_rdata;
    logic        interrupt_state = 1'b0;
    logic        irq;
    logic [4:0]  irq_id;

    nanorv32_irq_ctrl #(.IRQ_NB(8), .IRQ_EDGE(EDGE)) dut (
        .clk             (clk),
        .rst             (rst),
        .irq_src         (irq_src),
        .cfg_sel         (cfg_sel),
        .cfg_we          (cfg_we),
        .cfg_addr        (cfg_addr),
        .cfg_wdata       (cfg_wdata),
        .cfg_rdata       (cfg_rdata),
        .interrupt_state (interrupt_state),
        .irq             (irq),
        .irq_id          (irq_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          irq;
        bit [4:0]    id;
        bit          rd;
        bit [31:0]   rdata;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model, phrased as the controller's observable rules.
    int unsigned m_en, m_pend, m_psrc, m_id;
    bit          m_pist, m_requesting, m_servicing;

    logic [7:0]  src_v = '0;
    bit          ist_v = 1'b0;
    bit          rst_v = 1'b1;

    function automatic int unsigned lowest(input int unsigned v);
        for (int unsigned i = 0; i < 32; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_en = 0; m_pend = 0; m_psrc = 0; m_id = 0;
        m_pist = 0; m_requesting = 0; m_servicing = 0;
    endtask

    task automatic model_step();
        int unsigned cand, clr, rise, src, edges;
        bit ack, fall;
        if (rst) begin
            model_reset();
            return;
        end
        src   = 32'(irq_src);
        edges = 32'(EDGE);
        cand  = m_pend & m_en;
        ack   = interrupt_state && !m_pist;
        fall  = !interrupt_state && m_pist;
        clr   = 0;
        if (cfg_sel && cfg_we && cfg_addr == 2'd1) clr = cfg_wdata & edges;
        if (m_requesting && ack) clr |= (1 << m_id) & edges;
        rise  = src & ~m_psrc;
        if (m_requesting) begin
            if (ack) begin
                m_requesting = 0;
                m_servicing  = 1;
            end else if (((cand >> m_id) & 1) == 0) begin
                m_requesting = 0;
            end
        end else if (m_servicing) begin
            if (fall) m_servicing = 0;
        end else if (cand != 0 && !interrupt_state) begin
            m_id = lowest(cand);
            m_requesting = 1;
        end
        if (cfg_sel && cfg_we && cfg_addr == 2'd0) m_en = cfg_wdata & 32'hFF;
        m_pend = ((edges & ((m_pend & ~clr) | rise)) | (~edges & src)) & 32'hFF;
        m_psrc = src;
        m_pist = interrupt_state;
    endtask

    function automatic bit [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0: return m_en;
            2'd1: return m_pend;
            2'd2: return (m_id << 8) | (32'(m_servicing) << 1) | 32'(m_requesting);
            default: return 32'd0;
        endcase
    endfunction

    task automatic cyc(input bit sel, input bit we, input logic [1:0] a, input logic [31:0] wd);
        exp_t e;
        @(posedge clk);
        model_step();
        #1;
        rst = rst_v;
        irq_src = src_v;
        interrupt_state = ist_v;
        cfg_sel = sel; cfg_we = we; cfg_addr = a; cfg_wdata = wd;
        if (rst_v) model_reset();
        e.irq   = m_requesting;
        e.id    = 5'(m_id);
        e.rd    = sel && !we;
        e.rdata = model_read(a);
        q.push_back(e);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [1:0] a);
        cyc(1'b1, 1'b0, a, 32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (irq !== e.irq) begin
                    errors++;
                    $display("FAIL irq @%0t got %0b want %0b", $time, irq, e.irq);
                end
                checks++;
                if (irq_id !== e.id) begin
                    errors++;
                    $display("FAIL irq_id @%0t got %0d want %0d", $time, irq_id, e.id);
                end
                if (e.rd) begin
                    checks++;
                    if (cfg_rdata !== e.rdata) begin
                        errors++;
                        $display("FAIL rdata[%0d] @%0t got %h want %h", cfg_addr, $time, cfg_rdata, e.rdata);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        model_reset();
        // reset state
        rst_v = 1; rd(2'd2); rd(2'd0); rd(2'd1);
        rst_v = 0; rd(2'd2); rd(2'd1);

        // level src 3 request and service
        wr(2'd0, 32'h08); src_v = 8'h08; nop(3); rd(2'd2);
        ist_v = 1; nop(2); rd(2'd2); src_v = 8'h00; ist_v = 0; nop(2); rd(2'd2);

        // src 1 (level) and src 5 (edge) together: 1 first, then 5
        wr(2'd0, 32'h22); src_v = 8'h22; nop(3); rd(2'd2);
        ist_v = 1; nop(2); src_v = 8'h00; nop(1); rd(2'd1);
        ist_v = 0; nop(3); rd(2'd2);
        ist_v = 1; nop(2); rd(2'd1); ist_v = 0; nop(2);

        // edge src 2 pulse through service
        wr(2'd0, 32'h04); src_v = 8'h04; nop(1); src_v = 8'h00; nop(2); rd(2'd1);
        ist_v = 1; nop(1); rd(2'd1); rd(2'd2); ist_v = 0; nop(1); rd(2'd2); nop(2);

        // withdrawal by disabling in REQ
        wr(2'd0, 32'h08); src_v = 8'h08; nop(3); rd(2'd2);
        wr(2'd0, 32'h00); nop(2); rd(2'd1); rd(2'd2);

        // edge and W1C in the same cycle on src 0, then plain W1C
        src_v = 8'h00; nop(2); src_v = 8'h01; wr(2'd1, 32'h01); rd(2'd1);
        wr(2'd1, 32'h01); rd(2'd1); rd(2'd3); wr(2'd3, 32'hFFFF_FFFF); rd(2'd3);

        // reset during SERVICE
        src_v = 8'h00; nop(1); wr(2'd0, 32'h10); src_v = 8'h10; nop(3);
        ist_v = 1; nop(2); rd(2'd2);
        rst_v = 1; rd(2'd2); rd(2'd0); rd(2'd1);
        rst_v = 0; ist_v = 0; src_v = 8'h00; nop(2); rd(2'd2);

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            rst_v = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 3) == 0) src_v = 8'($urandom);
            if ($urandom_range(0, 5) == 0) ist_v = ~ist_v;
            case ($urandom_range(0, 7))
                0: wr(2'd0, $urandom);
                1: wr(2'd1, $urandom);
                2: wr(2'd3, $urandom);
                3, 4: rd(2'($urandom_range(0, 3)));
                default: nop(1);
            endcase
        end
        rst_v = 0;
        nop(2);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d want 0 pending expectations", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nanorv32_irq_ctrl.md
NANORV32_IRQ_CTRL -- requirements
Module: nanorv32_irq_ctrl

Interface
REQ-001 Parameter IRQ_NB, default 8, number of interrupt sources (1..32).
REQ-002 Parameter IRQ_EDGE, default all-zero, per-source type: bit set = rising-edge, bit clear = level.
REQ-003 The block has one clock and an asynchronous, active-high reset: clk input 1 clock, all flops on rising edge; rst input 1 asynchronous active-high reset.
REQ-004 irq_src  input  IRQ_NB  raw interrupt lines.
REQ-005 cfg_sel  input  1  register access strobe; cfg_we  input  1  write when set; cfg_addr  input  2  register index; cfg_wdata  input  32  write data; cfg_rdata  output  32  read data, combinational from registers.
REQ-006 interrupt_state  input  1  core in interrupt context (from flow control).
REQ-007 irq  output  1  interrupt request to flow control.
REQ-008 irq_id  output  5  index of the source being requested or serviced.

Function
REQ-009 Registers: 0 ENABLE (RW, bits IRQ_NB-1:0); 1 PENDING (RO for level, W1C for edge); 2 STATUS (RO: bit0 irq, bit1 in-service, bits 12:8 irq_id); 3 reads zero, writes ignored.
REQ-010 Level source pending bit equals its (synchronized) line each cycle; edge source pending bit is set on a 0->1 transition and held until W1C or acknowledge.
REQ-011 An edge arriving in the same cycle as its clear leaves the bit set (set wins).
REQ-012 A further edge on an already-pending source is not counted.
REQ-013 Candidate set = PENDING & ENABLE; winner = lowest set index (fixed priority).
REQ-014 FSM states IDLE, REQ, SERVICE; encoding in shared package.
REQ-015 IDLE: if candidate set non-empty and interrupt_state low, latch winner into irq_id and go to REQ next cycle.
REQ-016 REQ: irq = 1; acknowledge = rising edge of interrupt_state (compared to its registered copy).
REQ-017 REQ on acknowledge: go to SERVICE, clear the winner's pending bit if edge-type.
REQ-018 REQ without acknowledge, winner no longer in candidate set: irq drops next cycle, return to IDLE (withdrawal).
REQ-019 Acknowledge and withdrawal in the same cycle: acknowledge wins.
REQ-020 SERVICE: irq = 0; falling edge of interrupt_state returns to IDLE; no nesting.
REQ-021 irq is registered; request-to-irq latency is 1 cycle from candidate visible in IDLE.
REQ-022 ENABLE writes take effect the next cycle; PENDING W1C masked to edge-type bits.

Reset
REQ-023 On rst: state IDLE, irq 0, irq_id 0, ENABLE 0, PENDING 0, edge-history and interrupt_state copy 0.
REQ-024 Reset asserted mid-REQ or mid-SERVICE aborts immediately; no pending state survives.

Configuration
REQ-025 NANORV32_IRQ_SYNC_EN defined: two-flop synchronizer on every irq_src bit, reset to 0, adding 2 cycles of latency before edge detection/pending.
REQ-026 NANORV32_IRQ_SYNC_EN undefined: irq_src used directly; sources must be synchronous to clk.

Structure
REQ-027 Shared package/parameter include holds FSM state encodings, register indices, and IRQ_NB maximum.
REQ-028 One sub-module nanorv32_irq_prio: combinational lowest-index priority encoder returning valid and index.

Verification
REQ-029 Level src 3 high, ENABLE=0x08, interrupt_state low -> irq=1 with irq_id=3 two cycles later (no sync macro).
REQ-030 Src 1 and 5 pending and enabled together -> irq_id=1; after service end, src 5 requested next.
REQ-031 Edge src 2 (IRQ_EDGE=0x04) pulse, interrupt_state rises -> SERVICE, PENDING bit2 clears; interrupt_state falls -> IDLE, irq stays 0.
REQ-032 In REQ, write ENABLE=0 before acknowledge -> irq drops next cycle, state IDLE, PENDING unchanged.
REQ-033 Edge on src 0 in same cycle as W1C 0x01 -> PENDING bit0 remains 1.
REQ-034 rst asserted during SERVICE -> irq=0, ENABLE=0, PENDING=0, STATUS=0 immediately.
